arb_mux: RTL

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 130 +++++++++++++
 1 files changed

// File: rtl/arb_mux.sv
// Round-robin N:1 arbiter with a one-word registered output stage.
// Optional fixed-priority mode (lowest index wins, no pointer): define ARB_MUX_FIXED_PRIO_EN.
module arb_mux #(
  parameter int WIDTH  = 2,
  parameter int NUM_CH = 64,
  parameter int SEL_W  = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    sel_force,
  input  logic [SEL_W-1:0]        sel_chan,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  input  logic                    out_ready
);

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [SEL_W-1:0]        out_chan_q, out_chan_d;
  logic [SEL_W-1:0]        base_s;
  logic [NUM_CH-1:0]       sel_oh_s;
  logic [NUM_CH-1:0]       elig_s;
  logic [NUM_CH-1:0]       grant_oh_s;
  logic                    grant_found_s;
  logic [SEL_W-1:0]        grant_idx_s;
  logic [SEL_W-1:0]        scan_idx_s;
  logic                    scan_hit_s;
  logic [WIDTH-1:0]        grant_data_s;
  logic                    can_accept_s;
  logic                    in_xfer_s;

`ifdef ARB_MUX_FIXED_PRIO_EN
  assign base_s = {SEL_W{1'b0}};
`else
  logic [SEL_W-1:0]        ptr_q, ptr_d;
  assign base_s = ptr_q;
`endif

  assign can_accept_s = !out_valid_q | out_ready;

  // Eligible requests: everything valid, or only the forced channel.
  always_comb begin
    sel_oh_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh_s[i] = (sel_chan == SEL_W'(i));
    end
    if (sel_force) begin
      elig_s = in_valid & sel_oh_s;
    end else begin
      elig_s = in_valid;
    end
  end

  // Wrap-around search from base_s; index arithmetic wraps because NUM_CH is 2**SEL_W.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {SEL_W{1'b0}};
    scan_idx_s    = {SEL_W{1'b0}};
    scan_hit_s    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx_s    = base_s + SEL_W'(i);
      scan_hit_s    = !grant_found_s & elig_s[scan_idx_s];
      grant_idx_s   = scan_hit_s ? scan_idx_s : grant_idx_s;
      grant_found_s = grant_found_s | scan_hit_s;
    end
  end

  // Decode the winner into a one-hot and select its payload with constant slices.
  always_comb begin
    grant_oh_s   = {NUM_CH{1'b0}};
    grant_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      grant_oh_s[i] = grant_found_s & (grant_idx_s == SEL_W'(i));
      grant_data_s  = (grant_idx_s == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  assign in_xfer_s = grant_found_s & can_accept_s & !reset;
  assign in_ready  = in_xfer_s ? grant_oh_s : {NUM_CH{1'b0}};

  // Output stage and pointer next-state.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
`ifndef ARB_MUX_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (in_xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data_s;
      out_chan_d  = grant_idx_s;
`ifndef ARB_MUX_FIXED_PRIO_EN
      ptr_d       = grant_idx_s + {{(SEL_W-1){1'b0}}, 1'b1};
`endif
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset clears the held word immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_chan_q  <= {SEL_W{1'b0}};
`ifndef ARB_MUX_FIXED_PRIO_EN
      ptr_q       <= {SEL_W{1'b0}};
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifndef ARB_MUX_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
